// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register.
//   - skid_state_e : entry-count states of the stage (EMPTY/BUSY/FULL)
//   - CTRL_NOP     : all-zero control word; a bubble carries this
//   - per-stage control/payload widths and ID/EX control-field offsets
//   - occ_of_state : maps a state to the number of entries it holds
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Per-stage field widths.
    localparam int ID_EX_CTRL_W  = 10;
    localparam int ID_EX_DATA_W  = 133;
    localparam int EX_MEM_CTRL_W = 4;
    localparam int EX_MEM_DATA_W = 101;
    localparam int MEM_WB_CTRL_W = 2;
    localparam int MEM_WB_DATA_W = 69;

    // All-zero control never writes memory or the register file.
    localparam logic [ID_EX_CTRL_W-1:0] CTRL_NOP = '0;

    // ID/EX control-field bit offsets.
    localparam int CTRL_MEM_TO_REG = 0;
    localparam int CTRL_MEM_RD     = 1;
    localparam int CTRL_MEM_WR     = 2;
    localparam int CTRL_ALU_SRC_B  = 3;
    localparam int CTRL_ALU_OP_LSB = 4;
    localparam int CTRL_ALU_OP_W   = 5;
    localparam int CTRL_REG_WR     = 9;

    function automatic logic [1:0] occ_of_state(input skid_state_e s);
        logic [1:0] n;
        case (s)
            EMPTY:   n = 2'd0;
            BUSY:    n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one storage entry (valid/ctrl/data) of the pipeline stage.
//   clk_i    : rising-edge clock
//   rst_i    : synchronous reset, clears valid, ctrl and data
//   clr_i    : synchronous clear of valid and ctrl (data is kept)
//   load_i   : capture ctrl_i/data_i and mark the entry valid
//   unload_i : mark the entry empty, keeping ctrl/data
//   ctrl_i, data_i : values captured on load
//   valid_o, ctrl_o, data_o : stored entry
// Priority: rst_i > clr_i > load_i > unload_i.
module pipe_slot #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 133
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline-stage register with valid/ready
// handshake, synchronous flush and an optional two-entry skid buffer.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop every held and incoming beat this cycle
//   in_valid/in_ready : upstream handshake; in_ctrl/in_data carried fields
//   out_valid/out_ready : downstream handshake; out_ctrl/out_data presented
//   occupancy         : entries held (0..2)
//   dbg_state         : current EMPTY/BUSY/FULL state
//
// Handshake: a beat moves on a rising edge where valid & ready are both
// high on that side. The producer must hold its beat stable while valid
// is high and ready is low; the stage never withdraws out_valid without a
// send, flush or reset.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W  = ID_EX_DATA_W,
    parameter int CTRL_W  = ID_EX_CTRL_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [1:0]        dbg_state
);

    skid_state_e state_q, state_d;

    logic              accept, send;
    logic              main_load, main_unload, main_from_skid;
    logic              skid_load, skid_unload;
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
    logic [DATA_W-1:0] main_data, skid_data, main_data_d;

    // With the skid buffer, in_ready decodes only the state, so it does not
    // depend on out_ready. Without it, a stalled full stage is freed in the
    // same cycle that downstream takes the beat.
    if (SKID_EN) begin : g_rdy_skid
        assign in_ready = !rst && (state_q != FULL);
    end else begin : g_rdy_flow
        assign in_ready = !rst && (!main_valid || out_ready);
    end

    assign accept = in_valid && in_ready;
    assign send   = out_valid && out_ready;

    // Next-state and slot control. Without the skid buffer BUSY+accept
    // always coincides with send, so FULL is unreachable.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_unload    = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_unload    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (accept && send) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (send) begin
                    main_unload = 1'b1;
                    state_d     = EMPTY;
                end
            end
            FULL: begin
                if (send) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_unload    = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_d = main_from_skid ? skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (flush),
        .load_i   (main_load),
        .unload_i (main_unload),
        .ctrl_i   (main_ctrl_d),
        .data_i   (main_data_d),
        .valid_o  (main_valid),
        .ctrl_o   (main_ctrl),
        .data_o   (main_data)
    );

    if (SKID_EN) begin : g_skid
        pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk_i    (clk),
            .rst_i    (rst),
            .clr_i    (flush),
            .load_i   (skid_load),
            .unload_i (skid_unload),
            .ctrl_i   (in_ctrl),
            .data_i   (in_data),
            .valid_o  (skid_valid),
            .ctrl_o   (skid_ctrl),
            .data_o   (skid_data)
        );
    end else begin : g_no_skid
        logic unused_skid;
        assign skid_valid  = 1'b0;
        assign skid_ctrl   = '0;
        assign skid_data   = '0;
        assign unused_skid = skid_load ^ skid_unload;
    end

    assign out_valid = main_valid;
    // A bubble must never carry mem_wr/reg_wr downstream.
    assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
    assign out_data  = main_data;
    assign occupancy = occ_of_state(state_q);
    assign dbg_state = state_q;

    a_in_stable: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready && !flush) |=> ($stable(in_ctrl) && $stable(in_data)));

    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> out_valid);

    a_full_skid: assert property (@(posedge clk) disable iff (rst)
        (state_q == FULL) |-> skid_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int CW = 10;
    localparam int DW = 133;

    logic clk, rst;

    // SKID_EN=1 instance
    logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [CW-1:0] s_in_ctrl, s_out_ctrl;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [1:0]    s_occ, s_state;

    // SKID_EN=0 instance
    logic          n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [CW-1:0] n_in_ctrl, n_out_ctrl;
    logic [DW-1:0] n_in_data, n_out_data;
    logic [1:0]    n_occ, n_state;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occ), .dbg_state(s_state)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_ctrl(n_in_ctrl), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_ctrl(n_out_ctrl), .out_data(n_out_data),
        .occupancy(n_occ), .dbg_state(n_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [139:0] obs, input logic [139:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic s_drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        s_in_valid = v;
        s_in_ctrl  = c;
        s_in_data  = d;
    endtask

    task automatic n_drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        n_in_valid = v;
        n_in_ctrl  = c;
        n_in_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        s_flush = 1'b0; n_flush = 1'b0;
        s_out_ready = 1'b1; n_out_ready = 1'b1;
        s_drive(1'b1, 10'h3FF, 133'h99);
        n_drive(1'b0, '0, '0);

        // 1. reset held 3 cycles with a beat offered
        tick(); tick(); tick();
        check("rst_in_ready_low", s_in_ready, 1'b0);
        check("rst_out_valid", s_out_valid, 1'b0);
        check("rst_out_ctrl", s_out_ctrl, 10'h0);
        check("rst_out_data", s_out_data, 133'h0);
        check("rst_occ", s_occ, 2'd0);
        check("rst_state", s_state, 2'd0);
        check("rst_n_out_valid", n_out_valid, 1'b0);
        rst = 1'b0;
        s_drive(1'b0, '0, '0);
        #1;
        check("post_rst_in_ready", s_in_ready, 1'b1);
        check("post_rst_n_in_ready", n_in_ready, 1'b1);

        // 2. streaming 1..8 on both instances
        for (int i = 1; i <= 8; i++) begin
            s_drive(1'b1, CW'(i), DW'(i));
            n_drive(1'b1, CW'(i), DW'(i));
            tick();
            check("stream_s_valid", s_out_valid, 1'b1);
            check("stream_s_data", s_out_data, 140'(i));
            check("stream_s_ctrl", s_out_ctrl, 140'(i));
            check("stream_n_data", n_out_data, 140'(i));
            check("stream_n_valid", n_out_valid, 1'b1);
        end
        s_drive(1'b0, '0, '0);
        n_drive(1'b0, '0, '0);
        tick();
        check("stream_s_drain", s_out_valid, 1'b0);
        check("stream_s_occ0", s_occ, 2'd0);
        check("stream_n_drain", n_out_valid, 1'b0);

        // 3. stall with A, B, C
        s_drive(1'b1, 10'h001, 133'hA);
        tick();
        check("stall_occ1", s_occ, 2'd1);
        check("stall_a_out", s_out_data, 133'hA);
        s_out_ready = 1'b0;
        s_drive(1'b1, 10'h002, 133'hB);
        #1;
        check("stall_b_ready", s_in_ready, 1'b1);
        tick();
        check("stall_occ2", s_occ, 2'd2);
        check("stall_a_held", s_out_data, 133'hA);
        s_drive(1'b1, 10'h003, 133'hC);
        #1;
        check("stall_full_ready", s_in_ready, 1'b0);
        tick();
        check("stall_c_waits_occ", s_occ, 2'd2);
        s_out_ready = 1'b1;
        #1;
        check("stall_ready_registered", s_in_ready, 1'b0);
        tick();
        check("release_b_out", s_out_data, 133'hB);
        check("release_occ1", s_occ, 2'd1);
        tick();
        check("release_c_out", s_out_data, 133'hC);
        check("release_c_ctrl", s_out_ctrl, 10'h003);
        s_drive(1'b0, '0, '0);
        tick();
        check("release_empty", s_out_valid, 1'b0);

        // 4. flush while FULL with D offered
        s_out_ready = 1'b0;
        s_drive(1'b1, 10'h005, 133'hE);
        tick();
        s_drive(1'b1, 10'h006, 133'hF);
        tick();
        check("flush_pre_occ2", s_occ, 2'd2);
        s_drive(1'b1, 10'h007, 133'hD);
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        s_drive(1'b0, '0, '0);
        #1;
        check("flush_out_valid", s_out_valid, 1'b0);
        check("flush_out_ctrl", s_out_ctrl, 10'h0);
        check("flush_occ", s_occ, 2'd0);
        check("flush_in_ready", s_in_ready, 1'b1);
        check("flush_data_kept", s_out_data, 133'hE);
        s_out_ready = 1'b1;
        tick();
        check("flush_d_absent", s_out_valid, 1'b0);
        tick();
        check("flush_d_absent2", s_out_valid, 1'b0);

        // 5. bubble safety
        s_drive(1'b1, 10'h2A5, 133'h55);
        tick();
        check("bubble_beat_ctrl", s_out_ctrl, 10'h2A5);
        s_drive(1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bubble_ctrl0", s_out_ctrl, 10'h0);
            check("bubble_valid0", s_out_valid, 1'b0);
            check("bubble_data_kept", s_out_data, 133'h55);
        end

        // 6a. rst and flush together while FULL
        s_out_ready = 1'b0;
        s_drive(1'b1, 10'h011, 133'h71);
        tick();
        s_drive(1'b1, 10'h012, 133'h72);
        tick();
        s_drive(1'b0, '0, '0);
        check("sim_pre_occ2", s_occ, 2'd2);
        rst = 1'b1;
        s_flush = 1'b1;
        tick();
        check("sim_out_valid", s_out_valid, 1'b0);
        check("sim_out_ctrl", s_out_ctrl, 10'h0);
        check("sim_out_data", s_out_data, 133'h0);
        check("sim_occ", s_occ, 2'd0);
        check("sim_in_ready_rst", s_in_ready, 1'b0);
        rst = 1'b0;
        s_flush = 1'b0;
        s_out_ready = 1'b1;
        #1;
        check("sim_in_ready_after", s_in_ready, 1'b1);

        // 6b. SKID_EN=0 replace in the same edge
        n_drive(1'b1, 10'h021, 133'h81);
        tick();
        check("n_x_out", n_out_data, 133'h81);
        check("n_x_occ", n_occ, 2'd1);
        n_out_ready = 1'b0;
        n_drive(1'b1, 10'h022, 133'h82);
        #1;
        check("n_stall_ready", n_in_ready, 1'b0);
        n_out_ready = 1'b1;
        #1;
        check("n_pass_ready", n_in_ready, 1'b1);
        tick();
        check("n_y_out", n_out_data, 133'h82);
        check("n_y_ctrl", n_out_ctrl, 10'h022);
        check("n_y_occ", n_occ, 2'd1);
        n_drive(1'b0, '0, '0);
        tick();
        check("n_drain", n_out_valid, 1'b0);
        check("n_drain_occ", n_occ, 2'd0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
